// File: rtl/countdown_pkg.sv
// Shared constants and helpers for the countdown_seg7 display counter.
//   SEG_0..SEG_9 : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments off, shown for any non-decimal digit
//   max_count(n) : largest value of an n-bit unsigned counter (2^n - 1)
package countdown_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int unsigned max_count(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment decoder (purely combinational).
//   bcd : 4-bit digit; 10..15 are not decimal and blank the display
//   seg : segments {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_decoder
  import countdown_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: default assigned before the case so every path drives seg and no latch is inferred.
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_seg7.sv
// N-bit wrapping down-counter shown as two decimal digits on 7-segment displays.
//   clk      : board clock, all state on the rising edge
//   reset    : push-button reset, asynchronous assert, active-low
//   count    : current counter value (reset value 2^N-1)
//   display1 : units digit, active-low {g,f,e,d,c,b,a}
//   display2 : tens digit, same encoding (a leading zero is still shown)
// Parameters: N = counter width (1..6), DIV = clocks per decrement (>= 1).
module countdown_seg7
  import countdown_pkg::*;
#(
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] count,
  output logic [6:0]   display1,
  output logic [6:0]   display2
);

  localparam logic [N-1:0] MAX_COUNT = N'(max_count(N));

  // Reset asserts asynchronously everywhere, but its release is only seen by
  // the counting logic after two flops, so a button bounce near a clock edge
  // cannot leave half the state running.
  logic [1:0] sync_q;
  logic       run;
  logic       tick;

  // NOTE: the synchronizer flops carry an async reset so that run drops the
  // instant the button is pressed; only the release is delayed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run = sync_q[1];

  generate
    if (DIV == 1) begin : g_no_presc
      assign tick = run;
    end else begin : g_presc
      localparam int PW = $clog2(DIV);
      localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
      logic [PW-1:0] presc;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          presc <= '0;
        end else if (run) begin
          presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
      end

      assign tick = run && (presc == PRESC_LAST);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= MAX_COUNT;
    end else if (tick) begin
      count <= (count == '0) ? MAX_COUNT : count - N'(1);
    end
  end

  // count never exceeds 63, so a constant divide on an 8-bit copy yields both
  // decimal digits in one combinational step.
  logic [7:0] count_ext;
  logic [3:0] units;
  logic [3:0] tens;

  assign count_ext = 8'(count);
  assign units     = 4'(count_ext % 8'd10);
  assign tens      = 4'(count_ext / 8'd10);

  seg7_decoder u_units (
    .bcd (units),
    .seg (display1)
  );

  seg7_decoder u_tens (
    .bcd (tens),
    .seg (display2)
  );

endmodule

// File: tb/tb_countdown_seg7.sv
// Directed bench for countdown_seg7 at N = 2, 4, 6 (DIV = 1) and N = 4, DIV = 3,
// plus an exhaustive sweep of seg7_decoder.
module tb_countdown_seg7;

  logic clk;
  logic reset;

  logic [1:0] c2;
  logic [3:0] c4;
  logic [5:0] c6;
  logic [3:0] c4d3;
  logic [6:0] d1_2, d2_2, d1_4, d2_4, d1_6, d2_6, d1_4d3, d2_4d3;

  logic [3:0] dec_bcd;
  logic [6:0] dec_seg;

  int total_checks = 0;
  int fail_checks  = 0;

  countdown_seg7 #(.N(2), .DIV(1)) u_n2 (
    .clk(clk), .reset(reset), .count(c2), .display1(d1_2), .display2(d2_2));
  countdown_seg7 #(.N(4), .DIV(1)) u_n4 (
    .clk(clk), .reset(reset), .count(c4), .display1(d1_4), .display2(d2_4));
  countdown_seg7 #(.N(6), .DIV(1)) u_n6 (
    .clk(clk), .reset(reset), .count(c6), .display1(d1_6), .display2(d2_6));
  countdown_seg7 #(.N(4), .DIV(3)) u_n4d3 (
    .clk(clk), .reset(reset), .count(c4d3), .display1(d1_4d3), .display2(d2_4d3));

  seg7_decoder u_dec (.bcd(dec_bcd), .seg(dec_seg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment table written out independently of the design package.
  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      fail_checks++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected state k active ticks after counting started (k = 0: just released).
  task automatic check_all(input int k);
    int e2, e4, e6, e4d3;
    e2   = 3  - (k % 4);
    e4   = 15 - (k % 16);
    e6   = 63 - (k % 64);
    e4d3 = 15 - ((k / 3) % 16);
    check($sformatf("n2_count k=%0d", k), 32'(c2), 32'(e2));
    check($sformatf("n4_count k=%0d", k), 32'(c4), 32'(e4));
    check($sformatf("n6_count k=%0d", k), 32'(c6), 32'(e6));
    check($sformatf("n4d3_count k=%0d", k), 32'(c4d3), 32'(e4d3));
    check($sformatf("n4_units k=%0d", k), 32'(d1_4), 32'(seg_ref(e4 % 10)));
    check($sformatf("n4_tens k=%0d", k), 32'(d2_4), 32'(seg_ref(e4 / 10)));
    check($sformatf("n6_units k=%0d", k), 32'(d1_6), 32'(seg_ref(e6 % 10)));
    check($sformatf("n6_tens k=%0d", k), 32'(d2_6), 32'(seg_ref(e6 / 10)));
  endtask

  // Release reset between edges, confirm the two-edge hold, then wait a
  // bounded number of edges for the first decrement.
  task automatic release_and_start(input string phase);
    reset = 1'b1;
    step();
    check({phase, "_hold_edge1"}, 32'(c4), 32'd15);
    step();
    check({phase, "_hold_edge2"}, 32'(c4), 32'd15);
    for (int i = 0; i < 4 && c4 == 4'd15; i++) step();
    check({phase, "_first_dec"}, 32'(c4), 32'd14);
  endtask

  initial begin
    reset   = 1'b1;
    dec_bcd = 4'd0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("async_rst_n2", 32'(c2), 32'd3);
    check("async_rst_n4", 32'(c4), 32'd15);
    check("async_rst_n6", 32'(c6), 32'd63);
    check("async_rst_n6_tens", 32'(d2_6), 32'(7'b0000010));
    check("async_rst_n6_units", 32'(d1_6), 32'(7'b0110000));

    // Reset held for three clocks: everything stays at max.
    repeat (3) step();
    check("held_rst_n2", 32'(c2), 32'd3);
    check("held_rst_n4", 32'(c4), 32'd15);
    check("held_rst_n6", 32'(c6), 32'd63);
    check("held_rst_n4d3", 32'(c4d3), 32'd15);
    check("held_rst_n2_tens", 32'(d2_2), 32'(7'b1000000));
    check("held_rst_n2_units", 32'(d1_2), 32'(7'b0110000));
    check("held_rst_n4_tens", 32'(d2_4), 32'(7'b1111001));
    check("held_rst_n4_units", 32'(d1_4), 32'(7'b0010010));
    check("held_rst_n6_tens", 32'(d2_6), 32'(7'b0000010));
    check("held_rst_n6_units", 32'(d1_6), 32'(7'b0110000));

    release_and_start("rel1");
    check_all(1);
    for (int k = 2; k <= 56; k++) begin
      step();
      check_all(k);
      if (k == 15) check("n4_at_zero", 32'(c4), 32'd0);
      if (k == 16) check("n4_wrap_to_15", 32'(c4), 32'd15);
      if (k == 53) begin
        check("n6_ten_count", 32'(c6), 32'd10);
        check("n6_ten_tens", 32'(d2_6), 32'(7'b1111001));
        check("n6_ten_units", 32'(d1_6), 32'(7'b1000000));
      end
      if (k == 54) begin
        check("n6_nine_count", 32'(c6), 32'd9);
        check("n6_nine_tens", 32'(d2_6), 32'(7'b1000000));
        check("n6_nine_units", 32'(d1_6), 32'(7'b0010000));
      end
    end

    // Mid-count reset between edges, with the N=4 counter at 7.
    check("n4_before_midrst", 32'(c4), 32'd7);
    #2 reset = 1'b0;
    #1;
    check("midrst_n4", 32'(c4), 32'd15);
    check("midrst_n6", 32'(c6), 32'd63);
    check("midrst_n4d3", 32'(c4d3), 32'd15);
    check("midrst_n4_units", 32'(d1_4), 32'(7'b0010010));
    repeat (2) step();
    check("midrst_held_n4", 32'(c4), 32'd15);

    // Resume from max; prescaler restarts from zero.
    release_and_start("rel2");
    check_all(1);
    for (int k = 2; k <= 5; k++) begin
      step();
      check_all(k);
    end

    // Exhaustive decoder sweep.
    for (int d = 0; d < 16; d++) begin
      dec_bcd = 4'(d);
      #1;
      check($sformatf("dec_%0d", d), 32'(dec_seg), 32'(seg_ref(d)));
    end

    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule
